boot_loader: RTL
================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024: instruction memory depth in 32-bit words.
REQ-002 Parameter ADDR_BASE, default 32'h0: byte address of the first loaded word.
REQ-003 clk  input  1: single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 uart_empty  input  1: receive FIFO empty flag.
REQ-006 uart_in  input  8: receive FIFO data, valid the cycle after uart_rdreq is high.
REQ-007 uart_rdreq  output  1: receive FIFO pop request.
REQ-008 imem_we  output  1: instruction memory write strobe, one-cycle pulse per word.
REQ-009 imem_addr  output  32: instruction memory byte address.
REQ-010 imem_wdata  output  32: instruction memory write data.
REQ-011 cpu_run  output  1: releases the CPU; 0 holds the PC at ADDR_BASE and blocks CPU UART access.
REQ-012 busy  output  1: a load is in progress.
REQ-013 error  output  1: the announced length exceeded MAX_WORDS.
REQ-014 words_loaded  output  16: count of words written so far.

Function
REQ-015 The block SHALL implement states LEN, DATA, WR, DONE and ERR.
- Reset enters LEN.
REQ-016 Byte fetch: uart_rdreq SHALL assert for one cycle only in LEN or DATA, with uart_empty=0 and no fetch pending.
- The byte SHALL be captured from uart_in on the next posedge.
- At most one fetch is in flight.
- Peak rate is one byte per 2 cycles.
REQ-017 uart_rdreq SHALL never assert while uart_empty=1, and never in WR, DONE or ERR.
REQ-018 LEN: four bytes SHALL assemble a 32-bit word count N, little-endian (first byte is bits [7:0]).
REQ-019 After the 4th LEN byte is captured:
- N=0: go to DONE.
- N>MAX_WORDS: go to ERR.
- Otherwise: go to DATA with the word index at 0.
REQ-020 DATA: four bytes SHALL assemble one word, little-endian.
- Capturing the 4th byte SHALL move the state to WR.
REQ-021 WR SHALL last exactly one cycle, and in it:
- imem_we=1.
- imem_wdata = the assembled word.
- imem_addr = ADDR_BASE + 4*index (32-bit arithmetic, wrap on overflow).
REQ-022 On leaving WR:
- index and words_loaded SHALL increment.
- If index+1 = N, go to DONE; else go to DATA.
REQ-023 Latency from the capture of a word's 4th byte to its imem_we SHALL be 1 cycle.
- The first imem_we after the start of a burst with uart_empty held 0 occurs no earlier than cycle 16 after the first uart_rdreq.
REQ-024 imem_addr and imem_wdata SHALL hold their last values outside WR.
- imem_we SHALL be 0 in every other state.
REQ-025 DONE SHALL be terminal until reset:
- cpu_run=1, busy=0, error=0.
- uart_rdreq=0; UART bytes are left for the CPU.
REQ-026 ERR SHALL be terminal until reset:
- error=1, cpu_run=0, busy=0.
- No memory writes occur.
REQ-027 busy SHALL be 1 in LEN only after the first byte is fetched, and 1 throughout DATA and WR.
REQ-028 A uart_empty gap of any length in LEN or DATA SHALL stall assembly without losing or duplicating bytes.
REQ-029 words_loaded SHALL saturate at 16'hFFFF.
- It reaches that value only if MAX_WORDS ≥ 65535.

Reset
REQ-030 While rst_n=0, and immediately on its assertion, the outputs SHALL be:
- uart_rdreq=0, imem_we=0, cpu_run=0, busy=0, error=0.
- imem_addr=ADDR_BASE, imem_wdata=0, words_loaded=0.
- State LEN, byte and fetch-pending counters cleared.
REQ-031 Reset asserted mid-load SHALL abandon any partial word with no write.
- After release, the block restarts expecting a new length field.
- A fetch pending at reset SHALL be discarded.

Verification
REQ-032 Bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00 with uart_empty=0 -> the following, then cpu_run=1 and words_loaded=2:
- imem_we pulse 1: addr 0, data 32'h00000013.
- imem_we pulse 2: addr 4, data 32'h0000006F.
REQ-033 Bytes 00 00 00 00 -> DONE one cycle after the 4th capture, cpu_run=1, no imem_we.
REQ-034 Bytes 01 04 00 00 (N=1025) with MAX_WORDS=1024 -> error=1, cpu_run=0, no imem_we, uart_rdreq stays 0 afterwards.
REQ-035 Same stream as REQ-032 with uart_empty=1 for 5 cycles between every byte -> identical writes, and uart_rdreq never high while uart_empty=1.
REQ-036 rst_n pulsed low after 2 DATA bytes of word 0, then a full stream with N=1 and word 32'hDEADBEEF -> single write at addr 0 with data 32'hDEADBEEF, words_loaded=1.
REQ-037 ADDR_BASE=32'h100, N=3 -> writes at 32'h100, 32'h104, 32'h108.

Source files
------------

// File: rtl/boot_loader.sv
// UART boot loader: pulls a little-endian word count and that many 32-bit words
// from a receive FIFO, writes them into instruction memory, then releases the CPU.
module boot_loader #(
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_empty,
  input  logic [7:0]  uart_in,
  output logic        uart_rdreq,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_run,
  output logic        busy,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_WR, S_DONE, S_ERR} state_t;

  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  state_t      r_state;
  logic        r_pending;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_shift;
  logic [31:0] r_len;
  logic [31:0] r_index;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_run;
  logic        r_busy;
  logic        r_error;
  logic [15:0] r_words;

  logic        w_rdreq;
  logic [31:0] w_word;

  // The pop request must follow uart_empty in the same cycle, so it cannot be
  // registered; gating with rst_n keeps it low while reset is held.
  assign w_rdreq = rst_n && !uart_empty && !r_pending &&
                   (r_state == S_LEN || r_state == S_DATA);
  assign w_word  = {uart_in, r_shift[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LEN;
      r_pending  <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_shift    <= 32'h0;
      r_len      <= 32'h0;
      r_index    <= 32'h0;
      r_we       <= 1'b0;
      r_addr     <= ADDR_BASE;
      r_wdata    <= 32'h0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
      r_words    <= 16'h0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads
      // the pre-edge state and the last assignment to a register wins cleanly.
      r_we <= 1'b0;
      if (w_rdreq) begin
        r_pending <= 1'b1;
        if (r_state == S_LEN) r_busy <= 1'b1;
      end
      case (r_state)
        S_LEN: begin
          if (r_pending) begin
            r_pending  <= 1'b0;
            r_shift    <= w_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_len   <= w_word;
              r_index <= 32'h0;
              if (w_word == 32'h0) begin
                r_state <= S_DONE;
                r_run   <= 1'b1;
                r_busy  <= 1'b0;
              end else if (w_word > MAX_N) begin
                r_state <= S_ERR;
                r_error <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (r_pending) begin
            r_pending  <= 1'b0;
            r_shift    <= w_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state <= S_WR;
              r_we    <= 1'b1;
              r_addr  <= ADDR_BASE + {r_index[29:0], 2'b00};
              r_wdata <= w_word;
            end
          end
        end
        S_WR: begin
          r_index <= r_index + 32'd1;
          if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
          if (r_index + 32'd1 == r_len) begin
            r_state <= S_DONE;
            r_run   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign uart_rdreq   = w_rdreq;
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign cpu_run      = r_run;
  assign busy         = r_busy;
  assign error        = r_error;
  assign words_loaded = r_words;

endmodule
